argmax_out_stage: RTL and testbench
===================================

# argmax_out_stage

Streaming classifier head placed directly downstream of the final fully-connected layer (e.g. `layer_5_2_1_9`: M=5 outputs, T=9 bits). It consumes each output vector of M signed words over a valid/ready stream, tracks the running maximum, and emits one result per vector: the index and value of the largest element. Handshake semantics match the layer's master port, so the two blocks connect port-to-port.

## Interface

- `M`, default 5: words per input vector (M ≥ 2).
- `T`, default 9: word width in bits, signed two's complement.
- `logM`, default `$clog2(M)`: width of the index output.

- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  this block can accept a word this cycle.
- `data_in`  in  T  signed input word.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accepts result.
- `idx_out`  out  logM  index (0..M-1) of the maximum word.
- `max_out`  out  T  signed value of the maximum word.

## Operation

- Word accepted on a cycle when `s_valid && s_ready`. Transfer on `m_valid && m_ready`.
- Word counter `cnt` (0..M-1) increments on each accept and wraps to 0 after accepting word M-1.
- Running registers `best` (T bits, signed) and `best_idx` (logM bits):
  - accept with `cnt==0`: `best<=data_in`, `best_idx<=0`.
  - accept with `cnt>0`: if `data_in > best` (signed, strict), then `best<=data_in`, `best_idx<=cnt`; otherwise hold.
  - Ties resolve to the lowest index.
- Accept with `cnt==M-1`: the final compare result (including the current word) is written directly into the output registers `idx_out`/`max_out`, and `m_valid<=1`.
- Output registers hold while `m_valid && !m_ready`. On a transfer with no simultaneous final-word accept, `m_valid<=0`. On a transfer in the same cycle as a final-word accept, `m_valid` stays 1 and the outputs load the new result.
- `s_ready = !reset && (cnt != M-1 || !m_valid || m_ready)`.
  - Stalls only the final word of the next vector while the previous result is pending.
  - Combinational path from `m_ready` to `s_ready` is intentional.
- No arithmetic widening. Comparison is a T-bit signed compare. Values 0 and negatives are handled identically to positives.

## Timing

- Reset (synchronous): `cnt=0`, `m_valid=0`, `idx_out=0`, `max_out=0`, `best=0`, `best_idx=0`. `s_ready=0` while `reset` is high.
- Reset asserted mid-vector or with a result pending: the partial vector and the pending result are discarded. The first accepted word after reset deasserts is index 0.
- Latency: result visible (`m_valid=1`) in the cycle after the edge that accepts word M-1.
- Throughput: one word per cycle. With `m_ready` held high, back-to-back vectors stream with no bubbles, one result every M cycles.
- Gaps in `s_valid` anywhere in a vector are allowed. State holds and the index mapping is preserved.
- `m_valid` never deasserts without a transfer. `idx_out`/`max_out` are stable while `m_valid && !m_ready`.

## Test plan

- Vector {5,0,0,12,3}, `m_ready=1` -> one cycle after the 5th accept: `m_valid=1`, `idx_out=3`, `max_out=12`.
- Ties: {7,7,2,7,1} -> `idx_out=0`, `max_out=7`. Negatives: {-4,-1,-9,-2,-3} -> `idx_out=1`, `max_out=-1`.
- Backpressure: result for {1,2,3,4,5} pending with `m_ready=0` for 10 cycles while the next vector {9,0,0,0,0} streams in.
  - Required: first 4 words accepted, `s_ready=0` at `cnt==4`, outputs hold (4,5).
  - When `m_ready` rises, (4,5) transfers, word 5 is accepted that same cycle, and (0,9) is presented next cycle.
- Reset mid-operation: assert `reset` after 3 words of {8,1,1,1,1}, then send {0,0,6,0,0} -> `idx_out=2`, `max_out=6`. No stale result is emitted.
- Back-to-back: 4 random vectors with `s_valid=1` and `m_ready=1` continuously -> 4 results spaced exactly M cycles apart, each matching a reference argmax with lowest-index tie-break. Random `s_valid`/`m_ready` toggling gives identical result sequences.

Source files
------------

// File: rtl/argmax_out_stage.sv
// -----------------------------------------------------------------------------
// argmax_out_stage
//
// Streaming classifier head. Consumes vectors of M signed T-bit words over a
// valid/ready stream, tracks the running maximum, and presents one result per
// vector: the index and value of the largest word. Ties resolve to the lowest
// index because only a strictly greater word replaces the running best.
//
// Parameters
//   M     words per input vector (M >= 2)
//   T     word width, signed two's complement
//   logM  width of the index output
//
// Ports
//   clk      in   single clock, all state updates on posedge
//   reset    in   synchronous, active-high reset
//   s_valid  in   upstream word valid
//   s_ready  out  word can be accepted this cycle (combinational in m_ready)
//   data_in  in   signed input word
//   m_valid  out  result valid
//   m_ready  in   downstream accepts the result
//   idx_out  out  index (0..M-1) of the maximum word
//   max_out  out  signed value of the maximum word
// -----------------------------------------------------------------------------
module argmax_out_stage #(
  parameter int M    = 5,
  parameter int T    = 9,
  parameter int logM = $clog2(M)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [T-1:0]    data_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [logM-1:0]        idx_out,
  output logic signed [T-1:0]    max_out
);

  localparam logic [logM-1:0] LAST_IDX = logM'(M - 1);

  // Word position within the current vector.
  logic [logM-1:0]     r_cnt;
  // Running maximum of the words accepted so far in this vector.
  logic signed [T-1:0] r_best;
  logic [logM-1:0]     r_best_idx;
  // Result holding registers.
  logic                r_m_valid;
  logic [logM-1:0]     r_idx_out;
  logic signed [T-1:0] r_max_out;

  logic                w_last;
  logic                w_accept;
  logic                w_xfer;
  logic                w_take;
  logic signed [T-1:0] w_nxt_best;
  logic [logM-1:0]     w_nxt_idx;

  // True when the incoming word must become the new running best: always for
  // the first word of a vector, otherwise only when strictly greater. The
  // strict compare is what gives the lowest-index tie-break.
  function automatic logic take_word(input logic [logM-1:0]     cnt,
                                     input logic signed [T-1:0] word,
                                     input logic signed [T-1:0] best);
    return (cnt == '0) || (word > best);
  endfunction

  assign w_last   = (r_cnt == LAST_IDX);

  // Only the final word of a vector can stall, and only while the previous
  // result is still waiting; a same-cycle transfer frees the output registers
  // so the final word is accepted without a bubble.
  assign s_ready  = !reset && (!w_last || !r_m_valid || m_ready);

  assign w_accept = s_valid && s_ready;
  assign w_xfer   = r_m_valid && m_ready;

  assign w_take     = take_word(r_cnt, data_in, r_best);
  assign w_nxt_best = w_take ? data_in : r_best;
  // When the first word is taken r_cnt is zero, so r_cnt is the right index
  // in both take cases.
  assign w_nxt_idx  = w_take ? r_cnt : r_best_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_m_valid  <= 1'b0;
      r_idx_out  <= '0;
      r_max_out  <= '0;
    end else begin
      if (w_accept) begin
        r_best     <= w_nxt_best;
        r_best_idx <= w_nxt_idx;
        r_cnt      <= w_last ? '0 : r_cnt + logM'(1);
      end

      // Final word: the compare including the current word goes straight to
      // the output registers. A simultaneous transfer of the old result is
      // covered here too, since m_valid simply stays high.
      if (w_accept && w_last) begin
        r_m_valid <= 1'b1;
        r_idx_out <= w_nxt_idx;
        r_max_out <= w_nxt_best;
      end else if (w_xfer) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid = r_m_valid;
  assign idx_out = r_idx_out;
  assign max_out = r_max_out;

endmodule

// File: tb/tb_argmax_out_stage.sv
// -----------------------------------------------------------------------------
// tb_argmax_out_stage
//
// Self-checking bench for argmax_out_stage. A reference model (queue of words
// of the current vector, queue of expected results computed as a plain argmax
// over each completed vector) predicts m_valid, s_ready and every transferred
// result. Directed table vectors, backpressure, reset and random streams.
// -----------------------------------------------------------------------------
module tb_argmax_out_stage;

  localparam int M    = 5;
  localparam int T    = 9;
  localparam int logM = $clog2(M);

  typedef logic [M-1:0][T-1:0] words_t;

  typedef struct {
    words_t w;
    int     e_idx;
    int     e_max;
  } vec_t;

  logic                clk;
  logic                reset;
  logic                s_valid;
  logic                s_ready;
  logic signed [T-1:0] data_in;
  logic                m_valid;
  logic                m_ready;
  logic [logM-1:0]     idx_out;
  logic signed [T-1:0] max_out;

  argmax_out_stage #(.M(M), .T(T)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .data_in (data_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .idx_out (idx_out),
    .max_out (max_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int cur_q[$];
  int exp_idx_q[$];
  int exp_max_q[$];
  int got_idx_q[$];
  int got_max_q[$];
  int xfer_cyc[$];
  logic hold_v;
  int   hold_idx;
  int   hold_max;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic words_t mk(input int a0, input int a1, input int a2,
                                input int a3, input int a4);
    words_t r;
    r[0] = T'(a0); r[1] = T'(a1); r[2] = T'(a2); r[3] = T'(a3); r[4] = T'(a4);
    return r;
  endfunction

  function automatic words_t rnd_vec();
    words_t r;
    int v;
    for (int i = 0; i < M; i++) begin
      if ($urandom_range(0, 1) == 1)
        v = int'($urandom_range(0, 6)) - 3;
      else
        v = int'($urandom_range(0, (1 << T) - 1)) - (1 << (T - 1));
      r[i] = T'(v);
    end
    return r;
  endfunction

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic run_cycle(input logic sv, input logic signed [T-1:0] d,
                           input logic mr, output logic acc);
    logic pend;
    logic exp_srdy;
    int   bi;
    int   bm;
    s_valid = sv;
    data_in = d;
    m_ready = mr;
    #1;
    acc = 1'b0;
    if (reset) begin
      chk("rst_s_ready", s_ready, 0);
      hold_v = 1'b0;
    end else begin
      pend     = (exp_idx_q.size() > 0);
      exp_srdy = !((cur_q.size() == M - 1) && pend && !mr);
      chk("m_valid", m_valid, pend);
      chk("s_ready", s_ready, exp_srdy);
      if (hold_v) begin
        chk("hold_idx", idx_out, hold_idx);
        chk("hold_max", max_out, hold_max);
      end
      if (pend && mr) begin
        chk("res_idx", idx_out, exp_idx_q[0]);
        chk("res_max", max_out, exp_max_q[0]);
        got_idx_q.push_back(int'(idx_out));
        got_max_q.push_back(int'(max_out));
        xfer_cyc.push_back(cyc);
        void'(exp_idx_q.pop_front());
        void'(exp_max_q.pop_front());
      end
      hold_v   = pend && !mr;
      hold_idx = int'(idx_out);
      hold_max = int'(max_out);
      acc = sv && exp_srdy;
      if (acc) begin
        cur_q.push_back(int'(d));
        if (cur_q.size() == M) begin
          bi = 0;
          bm = cur_q[0];
          for (int i = 1; i < M; i++)
            if (cur_q[i] > bm) begin
              bm = cur_q[i];
              bi = i;
            end
          exp_idx_q.push_back(bi);
          exp_max_q.push_back(bm);
          cur_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    logic acc;
    reset = 1'b1;
    for (int i = 0; i < n; i++)
      run_cycle(1'($urandom_range(0, 1)), T'($urandom), 1'($urandom_range(0, 1)), acc);
    reset = 1'b0;
    cur_q.delete();
    exp_idx_q.delete();
    exp_max_q.delete();
    hold_v = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_idx_out", idx_out, 0);
    chk("rst_max_out", max_out, 0);
    chk("post_rst_s_ready", s_ready, 1);
  endtask

  // mode 0: s_valid and m_ready held high; mode 1: both randomly toggled.
  task automatic send_vec(input words_t w, input int mode);
    logic acc;
    logic sv;
    logic mr;
    int   p = 0;
    int   g = 0;
    while (p < M && g < 300) begin
      sv = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      mr = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      run_cycle(sv, $signed(w[p]), mr, acc);
      if (acc) p++;
      g++;
    end
    if (p < M) chk("send_timeout", p, M);
  endtask

  task automatic drain();
    logic acc;
    int g = 0;
    while (exp_idx_q.size() > 0 && g < 50) begin
      run_cycle(1'b0, '0, 1'b1, acc);
      g++;
    end
    if (exp_idx_q.size() > 0) chk("drain_timeout", exp_idx_q.size(), 0);
  endtask

  vec_t   tbl[6];
  words_t bb[4];
  int     gi1[$];
  int     gm1[$];

  initial begin
    logic   acc;
    int     p;
    words_t w2;

    reset   = 1'b1;
    s_valid = 1'b0;
    data_in = '0;
    m_ready = 1'b0;
    hold_v  = 1'b0;

    tbl[0] = '{w: mk(5, 0, 0, 12, 3),          e_idx: 3, e_max: 12};
    tbl[1] = '{w: mk(7, 7, 2, 7, 1),           e_idx: 0, e_max: 7};
    tbl[2] = '{w: mk(-4, -1, -9, -2, -3),      e_idx: 1, e_max: -1};
    tbl[3] = '{w: mk(0, 0, 0, 0, 0),           e_idx: 0, e_max: 0};
    tbl[4] = '{w: mk(-256, -256, -256, -256, 255), e_idx: 4, e_max: 255};
    tbl[5] = '{w: mk(-256, -256, -256, -256, -256), e_idx: 0, e_max: -256};

    do_reset(3);

    // Directed table: result must be visible right after the final accept.
    for (int k = 0; k < 6; k++) begin
      send_vec(tbl[k].w, 0);
      chk("tbl_m_valid", m_valid, 1);
      chk("tbl_idx", idx_out, tbl[k].e_idx);
      chk("tbl_max", max_out, tbl[k].e_max);
      drain();
    end

    // Backpressure: next vector stalls only on its final word.
    send_vec(mk(1, 2, 3, 4, 5), 0);
    w2 = mk(9, 0, 0, 0, 0);
    p = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b1, $signed(w2[p]), 1'b0, acc);
      if (acc) p++;
    end
    chk("bp_accepted", p, 4);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_idx_hold", idx_out, 4);
    chk("bp_max_hold", max_out, 5);
    run_cycle(1'b1, $signed(w2[4]), 1'b1, acc);
    chk("bp_final_acc", acc, 1);
    chk("bp_next_valid", m_valid, 1);
    chk("bp_next_idx", idx_out, 0);
    chk("bp_next_max", max_out, 9);
    drain();

    // Reset mid-vector: partial vector discarded, indexing restarts at 0.
    w2 = mk(8, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, $signed(w2[i]), 1'b1, acc);
    do_reset(2);
    send_vec(mk(0, 0, 6, 0, 0), 0);
    chk("rmid_valid", m_valid, 1);
    chk("rmid_idx", idx_out, 2);
    chk("rmid_max", max_out, 6);
    drain();

    // Reset with a result pending: it must not be emitted afterwards.
    send_vec(mk(3, 1, 1, 1, 1), 0);
    do_reset(1);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b1, acc);

    // Back-to-back random vectors: results exactly M cycles apart.
    for (int k = 0; k < 4; k++) bb[k] = rnd_vec();
    got_idx_q.delete();
    got_max_q.delete();
    xfer_cyc.delete();
    for (int k = 0; k < 4; k++) send_vec(bb[k], 0);
    drain();
    chk("b2b_count", xfer_cyc.size(), 4);
    for (int k = 1; k < xfer_cyc.size(); k++)
      chk("b2b_spacing", xfer_cyc[k] - xfer_cyc[k-1], M);
    gi1 = got_idx_q;
    gm1 = got_max_q;

    // Same vectors with random s_valid/m_ready: identical result sequence.
    got_idx_q.delete();
    got_max_q.delete();
    for (int k = 0; k < 4; k++) send_vec(bb[k], 1);
    drain();
    chk("replay_count", got_idx_q.size(), gi1.size());
    for (int k = 0; k < gi1.size() && k < got_idx_q.size(); k++) begin
      chk("replay_idx", got_idx_q[k], gi1[k]);
      chk("replay_max", got_max_q[k], gm1[k]);
    end

    // Longer random stream with toggling handshakes.
    for (int k = 0; k < 30; k++) send_vec(rnd_vec(), 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got %0d want 0", cyc);
    $fatal(1, "timeout");
  end

endmodule
